// File: rtl/clean_cycle_scheduler.sv
// Hood self-clean sequencer: arms clean mode from standby, counts down in seconds, requests standby on completion.
// Define CLEAN_REMINDER_EN to build the fan run-time accumulator behind clean_reminder.
module clean_cycle_scheduler #(
  parameter int unsigned       MODE_W      = 3,
  parameter logic [MODE_W-1:0] STAND_CODE  = 3'd0,
  parameter logic [MODE_W-1:0] CLEAN_CODE  = 3'd4,
  parameter int unsigned       TICK_DIV    = 100_000_000,
  parameter int unsigned       CLEAN_SECS  = 180,
  parameter int unsigned       CNT_W       = 8,
  parameter int unsigned       ARM_TIMEOUT = 255,
  parameter int unsigned       REMIND_SECS = 36000,
  parameter int unsigned       RUN_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] current_mode,
  input  logic              clean_mode_toggle,
  input  logic              abort,
  input  logic              fan_running,
  output logic              enter_clean_req,
  output logic              exit_clean_req,
  output logic              clean_active,
  output logic [CNT_W-1:0]  clean_remaining,
  output logic              clean_done,
  output logic              clean_aborted,
  output logic              clean_reminder
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SECS_INIT = CNT_W'(CLEAN_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_FINISH
  } state_e;

  state_e           state_q;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [ARM_W-1:0] wait_q;
  logic [CNT_W-1:0] remaining_q;
  logic             enter_q, exit_q, active_q, done_q, aborted_q;
  logic             tick;
  logic             arm_go;

  assign tick   = (presc_q == PRE_LAST);
  assign arm_go = (state_q == S_ARM) && !abort && (current_mode == CLEAN_CODE);

  // Restarting the prescaler on RUN entry makes the first second a full one.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    if (arm_go) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      remaining_q <= '0;
      enter_q     <= 1'b0;
      exit_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      enter_q   <= 1'b0;
      exit_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clean_mode_toggle && (current_mode == STAND_CODE)) begin
            state_q <= S_ARM;
            wait_q  <= '0;
            enter_q <= 1'b1;
          end
        end
        S_ARM: begin
          wait_q <= wait_q + ARM_W'(1);
          if (abort) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
          end else if (current_mode == CLEAN_CODE) begin
            state_q     <= S_RUN;
            remaining_q <= SECS_INIT;
            active_q    <= 1'b1;
          end else if (wait_q == ARM_LAST) begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // Losing the mode or an abort wins over a coincident final tick.
          if (abort || (current_mode != CLEAN_CODE)) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            active_q    <= 1'b0;
            aborted_q   <= 1'b1;
          end else if (tick) begin
            if (remaining_q == CNT_ONE) begin
              remaining_q <= '0;
              state_q     <= S_FINISH;
            end else begin
              remaining_q <= remaining_q - CNT_ONE;
            end
          end
        end
        S_FINISH: begin
          done_q   <= 1'b1;
          exit_q   <= 1'b1;
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CLEAN_REMINDER_EN
  localparam logic [RUN_W-1:0] REMIND_MAX = RUN_W'(REMIND_SECS);

  logic [RUN_W-1:0] acc_q, acc_d;
  logic             reminder_q;

  always_comb begin
    acc_d = acc_q;
    if (state_q == S_FINISH)
      acc_d = '0;
    else if (tick && fan_running && (acc_q != REMIND_MAX))
      acc_d = acc_q + RUN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      reminder_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      reminder_q <= (acc_d == REMIND_MAX);
    end
  end

  assign clean_reminder = reminder_q;
`else
  logic [RUN_W:0] unused_cfg;
  assign unused_cfg     = {fan_running, RUN_W'(REMIND_SECS)};
  assign clean_reminder = 1'b0;
`endif

  assign enter_clean_req = enter_q;
  assign exit_clean_req  = exit_q;
  assign clean_active    = active_q;
  assign clean_remaining = remaining_q;
  assign clean_done      = done_q;
  assign clean_aborted   = aborted_q;

endmodule
